reg_wr_arbiter: RTL and testbench



---
 rtl/reg_wr_arbiter_pkg.sv | 22 ++
 rtl/reg_wr_arbiter_if.sv | 31 +++
 rtl/reg_wr_arbiter_rr_arbiter.sv | 38 +++
 rtl/reg_wr_arbiter.sv | 101 ++++++++++
 tb/tb_reg_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the register-bank write arbiter.
package reg_wr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_NUM_REG = 4;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 8;

  // Ceiling log2, never below 1 so a 2-requester pointer still has a bit.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester-side and register-bank-side signals of the write arbiter.
interface reg_wr_arbiter_if
  import reg_wr_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_REG = DEF_NUM_REG,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REG-1:0]        reg_en_o;
  logic [DATA_W-1:0]         reg_d_o;
  logic                      err_o;
  logic                      busy_o;

  // The master side is the requesters plus the register bank they feed.
  modport master (
    output req_i, addr_i, data_i,
    input  gnt_o, reg_en_o, reg_d_o, err_o, busy_o
  );

  modport slave (
    input  req_i, addr_i, data_i,
    output gnt_o, reg_en_o, reg_d_o, err_o, busy_o
  );

endinterface

// File: rtl/reg_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               vld
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] cur;
  logic [PTR_W-1:0]   off;
  int                 sum;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr, then find the lowest set bit.
    rot = NUM_REQ'({req, req} >> ptr);
    cur = rot;
    off = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!vld && cur[0]) begin
        vld = 1'b1;
        off = PTR_W'(i);
      end
      cur = cur >> 1;
    end

    sum = int'(ptr) + int'(off);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    gnt_idx = vld ? PTR_W'(sum) : '0;
    gnt     = vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin write controller sharing one D bus and per-register enables.
module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_REG = DEF_NUM_REG,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  reg_wr_arbiter_if.slave  bus
);

  localparam int PTR_W = log2(NUM_REQ);

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   nxt_ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   sel_nxt_ptr;
  logic               addr_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req     (bus.req_i),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  // Winner's address/data slices and the pointer value that follows it.
  always_comb begin
    sel_addr    = ADDR_W'(bus.addr_i >> (int'(arb_idx) * ADDR_W));
    sel_data    = DATA_W'(bus.data_i >> (int'(arb_idx) * DATA_W));
    sel_nxt_ptr = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
  end

  assign addr_ok = int'(addr_q) < NUM_REG;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Transaction capture in IDLE; pointer advances as WRITE completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      nxt_ptr_q <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && arb_vld) begin
        gnt_q     <= arb_gnt;
        addr_q    <= sel_addr;
        data_q    <= sel_data;
        nxt_ptr_q <= sel_nxt_ptr;
      end
      if (state_q == ST_WRITE) rr_ptr_q <= nxt_ptr_q;
    end
  end

  // Outputs decode only from registered state, so reset clears them at once.
  always_comb begin
    state_d      = state_q;
    bus.gnt_o    = '0;
    bus.reg_en_o = '0;
    bus.reg_d_o  = '0;
    bus.err_o    = 1'b0;
    bus.busy_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d     = ST_IDLE;
        bus.gnt_o   = gnt_q;
        bus.busy_o  = 1'b1;
        bus.reg_d_o = data_q;
        if (addr_ok) bus.reg_en_o = NUM_REG'(1) << addr_q;
        else         bus.err_o    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed and randomized checks of reg_wr_arbiter against a round-robin model.
module tb_reg_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_REG = 3;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wr_arbiter_if #(
    .NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) bus ();

  reg_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [NUM_REQ-1:0] req_v;
  logic [ADDR_W-1:0]  addr_v [NUM_REQ];
  logic [DATA_W-1:0]  data_v [NUM_REQ];
  int                 wait_m [NUM_REQ];
  logic [DATA_W-1:0]  bank   [NUM_REG];
  logic [DATA_W-1:0]  bank_m [NUM_REG];
  logic               bank_clr;
  int                 ptr_m;

  // External register bank: not reset by rst, so dropped writes stay visible.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REG; i++) begin
      if (bank_clr)                 bank[i] <= '0;
      else if (bus.reg_en_o[i])     bank[i] <= bus.reg_d_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_i = req_v;
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.addr_i[r*ADDR_W +: ADDR_W] = addr_v[r];
      bus.data_i[r*DATA_W +: DATA_W] = data_v[r];
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] rq, input int ptr);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (rq[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "/gnt0"},  32'(bus.gnt_o),    0);
    chk({tag, "/en0"},   32'(bus.reg_en_o), 0);
    chk({tag, "/d0"},    32'(bus.reg_d_o),  0);
    chk({tag, "/err0"},  32'(bus.err_o),    0);
    chk({tag, "/busy0"}, 32'(bus.busy_o),   0);
  endtask

  // Entered at a negedge in IDLE with inputs set; leaves at the next IDLE negedge.
  task automatic write_cycle(input int exp_w, input bit hold, input string tag);
    int w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    w = (exp_w >= 0) ? exp_w : pick(req_v, ptr_m);
    a = addr_v[w];
    d = data_v[w];
    @(negedge clk);
    chk({tag, "/gnt"},  32'(bus.gnt_o),    32'(1) << w);
    chk({tag, "/busy"}, 32'(bus.busy_o),   1);
    chk({tag, "/d"},    32'(bus.reg_d_o),  32'(d));
    chk({tag, "/en"},   32'(bus.reg_en_o), (int'(a) < NUM_REG) ? (32'(1) << a) : 0);
    chk({tag, "/err"},  32'(bus.err_o),    (int'(a) < NUM_REG) ? 0 : 1);
    chk({tag, "/starve"}, 32'(wait_m[w] < NUM_REQ), 1);
    for (int r = 0; r < NUM_REQ; r++) if (req_v[r] && r != w) wait_m[r]++;
    wait_m[w] = 0;
    if (int'(a) < NUM_REG) bank_m[a] = d;
    ptr_m = (w + 1) % NUM_REQ;
    // Inputs change mid-WRITE to prove they are ignored.
    for (int r = 0; r < NUM_REQ; r++) if (!req_v[r]) data_v[r] = 8'($urandom);
    if (!hold) req_v[w] = 1'b0;
    drive();
    @(negedge clk);
    chk({tag, "/idle_gnt"},  32'(bus.gnt_o),    0);
    chk({tag, "/idle_en"},   32'(bus.reg_en_o), 0);
    chk({tag, "/idle_busy"}, 32'(bus.busy_o),   0);
    for (int i = 0; i < NUM_REG; i++) chk($sformatf("%s/q%0d", tag, i), 32'(bank[i]), 32'(bank_m[i]));
  endtask

  task automatic clear_reqs();
    req_v = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_v[r] = '0;
      data_v[r] = '0;
      wait_m[r] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bank_clr = 1'b1;
    clear_reqs();
    for (int i = 0; i < NUM_REG; i++) bank_m[i] = '0;
    ptr_m = 0;
    req_v = '1;
    drive();
    repeat (2) @(negedge clk);
    check_quiet("reset");

    // First write after reset: requester 1 to register 2.
    rst = 1'b0;
    bank_clr = 1'b0;
    clear_reqs();
    req_v = 4'b0010;
    addr_v[1] = 2'd2;
    data_v[1] = 8'hA5;
    drive();
    write_cycle(1, 1'b0, "first");
    check_quiet("first_after");

    // Contention from a fresh pointer: grants 0,1,2 then 3 (out of range).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    clear_reqs();
    req_v = 4'b1111;
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_v[r] = ADDR_W'(r);
      data_v[r] = 8'h10 + 8'(r);
    end
    drive();
    for (int r = 0; r < NUM_REQ; r++) write_cycle(r, 1'b0, $sformatf("cont%0d", r));

    // Wrap: grant 3, then 0 and 3 compete with pointer back at 0.
    req_v = 4'b1000;
    addr_v[3] = 2'd1;
    data_v[3] = 8'h33;
    drive();
    write_cycle(3, 1'b0, "wrap3");
    req_v = 4'b1001;
    addr_v[0] = 2'd0;
    data_v[0] = 8'hC0;
    addr_v[3] = 2'd2;
    data_v[3] = 8'hC3;
    drive();
    write_cycle(0, 1'b0, "wrap0");
    write_cycle(3, 1'b0, "wrap3b");

    // Out-of-range address still acknowledged.
    req_v = 4'b0100;
    addr_v[2] = 2'd3;
    data_v[2] = 8'hEE;
    drive();
    write_cycle(2, 1'b0, "oor");

    // Reset in the middle of WRITE drops the write and rewinds the pointer.
    req_v = 4'b0001;
    addr_v[0] = 2'd0;
    data_v[0] = 8'h3C;
    drive();
    @(posedge clk);
    #1;
    chk("midrst/busy_pre", 32'(bus.busy_o), 1);
    #2 rst = 1'b1;
    #1;
    check_quiet("midrst");
    @(posedge clk);
    #1;
    chk("midrst/q0", 32'(bank[0]), 32'(bank_m[0]));
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    clear_reqs();
    req_v = 4'b0110;
    addr_v[1] = 2'd1;
    data_v[1] = 8'h61;
    addr_v[2] = 2'd2;
    data_v[2] = 8'h62;
    drive();
    write_cycle(1, 1'b0, "postrst1");
    write_cycle(2, 1'b0, "postrst2");

    // Held request re-arms with whatever data_i shows at the next IDLE.
    req_v = 4'b0001;
    addr_v[0] = 2'd1;
    data_v[0] = 8'h77;
    drive();
    write_cycle(0, 1'b1, "hold1");
    data_v[0] = 8'h5A;
    drive();
    write_cycle(0, 1'b0, "hold2");

    // Randomized traffic obeying the hold-until-grant handshake.
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_v[r] && $urandom_range(1, 0) == 1) begin
          req_v[r]  = 1'b1;
          addr_v[r] = ADDR_W'($urandom_range(3, 0));
          data_v[r] = 8'($urandom);
          wait_m[r] = 0;
        end
      end
      if (req_v == '0) begin
        req_v[0]  = 1'b1;
        addr_v[0] = ADDR_W'($urandom_range(3, 0));
        data_v[0] = 8'($urandom);
        wait_m[0] = 0;
      end
      drive();
      write_cycle(-1, 1'b0, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
